// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the multiply/divide unit.
//   - md_op_e      : operation codes carried on md_op
//   - cycle defaults for MULT/MULTU and DIV/DIVU latency
//   - CNT_W        : width of the busy counter
//   - is_md_start  : op starts a multi-cycle operation (MULT..DIVU)
//   - is_md_use    : op touches the MDU at all (MULT..MTLO); used for stalls
package md_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MFHI  = 4'd5,
        MD_MFLO  = 4'd6,
        MD_MTHI  = 4'd7,
        MD_MTLO  = 4'd8
    } md_op_e;

    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;
    localparam int unsigned CNT_W           = 8;

    function automatic logic is_md_start(input logic [3:0] op);
        return (op >= 4'(MD_MULT)) && (op <= 4'(MD_DIVU));
    endfunction

    function automatic logic is_md_use(input logic [3:0] op);
        return (op >= 4'(MD_MULT)) && (op <= 4'(MD_MTLO));
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: combinational datapath for MULT/MULTU/DIV/DIVU.
//   i_md_op         : operation code (md_op_e)
//   i_a, i_b        : rs / rt operands
//   o_hi, o_lo      : HI/LO result (0 for non-arithmetic ops)
//   o_div_by_zero   : DIV/DIVU with i_b == 0; results are then meaningless
module mdu_arith
    import md_pkg::*;
(
    input  logic [3:0]  i_md_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo,
    output logic        o_div_by_zero
);

    logic signed [63:0] w_sprod;
    logic        [63:0] w_uprod;
    logic        [31:0] w_ua;
    logic        [31:0] w_ub;
    logic        [31:0] w_uq;
    logic        [31:0] w_ur;
    logic        [31:0] w_sq;
    logic        [31:0] w_sr;
    logic        [31:0] w_dq;
    logic        [31:0] w_dr;
    logic               w_bzero;

    assign w_sprod = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
    assign w_uprod = {32'd0, i_a} * {32'd0, i_b};
    assign w_bzero = (i_b == '0);

    // Signed divide done on magnitudes so 0x80000000 / -1 wraps to
    // 0x80000000 with remainder 0 instead of relying on simulator overflow.
    assign w_ua = i_a[31] ? (~i_a + 32'd1) : i_a;
    assign w_ub = i_b[31] ? (~i_b + 32'd1) : i_b;
    assign w_uq = w_bzero ? '0 : (w_ua / w_ub);
    assign w_ur = w_bzero ? '0 : (w_ua % w_ub);
    assign w_sq = (i_a[31] ^ i_b[31]) ? (~w_uq + 32'd1) : w_uq;
    assign w_sr = i_a[31] ? (~w_ur + 32'd1) : w_ur;

    assign w_dq = w_bzero ? '0 : (i_a / i_b);
    assign w_dr = w_bzero ? '0 : (i_a % i_b);

    always_comb begin
        o_hi          = '0;
        o_lo          = '0;
        o_div_by_zero = 1'b0;
        case (i_md_op)
            4'(MD_MULT): begin
                o_hi = w_sprod[63:32];
                o_lo = w_sprod[31:0];
            end
            4'(MD_MULTU): begin
                o_hi = w_uprod[63:32];
                o_lo = w_uprod[31:0];
            end
            4'(MD_DIV): begin
                o_hi          = w_sr;
                o_lo          = w_sq;
                o_div_by_zero = w_bzero;
            end
            4'(MD_DIVU): begin
                o_hi          = w_dr;
                o_lo          = w_dq;
                o_div_by_zero = w_bzero;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu.sv
// mdu: E-stage multiply/divide unit owning HI/LO.
//   clk, reset   : clock; asynchronous active-high reset
//   start        : pulse when a MULT/MULTU/DIV/DIVU sits in E
//   md_op        : operation code (md_op_e)
//   a, b         : forwarded rs / rt operands
//   busy         : multi-cycle operation in flight
//   md_out       : HI for MFHI, LO for MFLO, else 0 (combinational)
//   hi_o, lo_o   : architectural HI/LO for debug
// Results are computed at the accepting edge and held in pending
// registers; HI/LO only change on the final busy edge.
module mdu
    import md_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] md_out,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic [31:0]      r_pend_hi;
    logic [31:0]      r_pend_lo;
    logic             r_pend_dbz;
    logic             r_busy;
    logic [CNT_W-1:0] r_cnt;

    logic [31:0]      w_hi;
    logic [31:0]      w_lo;
    logic             w_dbz;
    logic             w_is_mult;

    mdu_arith u_arith (
        .i_md_op       (md_op),
        .i_a           (a),
        .i_b           (b),
        .o_hi          (w_hi),
        .o_lo          (w_lo),
        .o_div_by_zero (w_dbz)
    );

    assign w_is_mult = (md_op == 4'(MD_MULT)) || (md_op == 4'(MD_MULTU));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hi       <= '0;
            r_lo       <= '0;
            r_pend_hi  <= '0;
            r_pend_lo  <= '0;
            r_pend_dbz <= 1'b0;
            r_busy     <= 1'b0;
            r_cnt      <= '0;
        end else if (r_busy) begin
            // Everything else, including new starts and MTHI/MTLO, is
            // ignored until the in-flight operation retires.
            if (r_cnt == CNT_ONE) begin
                if (!r_pend_dbz) begin
                    r_hi <= r_pend_hi;
                    r_lo <= r_pend_lo;
                end
                r_busy <= 1'b0;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt - CNT_ONE;
            end
        end else if (start && is_md_start(md_op)) begin
            r_pend_hi  <= w_hi;
            r_pend_lo  <= w_lo;
            r_pend_dbz <= w_dbz;
            r_busy     <= 1'b1;
            r_cnt      <= w_is_mult ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
        end else if (md_op == 4'(MD_MTHI)) begin
            r_hi <= a;
        end else if (md_op == 4'(MD_MTLO)) begin
            r_lo <= a;
        end
    end

    always_comb begin
        md_out = '0;
        if (md_op == 4'(MD_MFHI)) begin
            md_out = r_hi;
        end else if (md_op == 4'(MD_MFLO)) begin
            md_out = r_lo;
        end
    end

    assign busy = r_busy;
    assign hi_o = r_hi;
    assign lo_o = r_lo;

endmodule

// File: tb/tb_mdu.sv
module tb_mdu;
    import md_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  md_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] md_out;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int total;
    int bad;
    logic [31:0] mdl_hi;
    logic [31:0] mdl_lo;

    mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk    (clk),
        .reset  (rst),
        .start  (start),
        .md_op  (md_op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .md_out (md_out),
        .hi_o   (hi_o),
        .lo_o   (lo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: architectural result using 64-bit host arithmetic.
    task automatic ref_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        longint          sx;
        longint          sy;
        longint          p;
        longint          q;
        longint          r;
        longint unsigned up;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (op)
            4'(MD_MULT): begin
                p = sx * sy;
                mdl_hi = p[63:32];
                mdl_lo = p[31:0];
            end
            4'(MD_MULTU): begin
                up = longint'(x) * longint'(y);
                mdl_hi = up[63:32];
                mdl_lo = up[31:0];
            end
            4'(MD_DIV): begin
                if (y != 0) begin
                    q = sx / sy;
                    r = sx % sy;
                    mdl_hi = r[31:0];
                    mdl_lo = q[31:0];
                end
            end
            4'(MD_DIVU): begin
                if (y != 0) begin
                    mdl_hi = x % y;
                    mdl_lo = x / y;
                end
            end
            default: ;
        endcase
    endtask

    // Issue op, count busy cycles, optionally disturb the inputs on one busy cycle.
    task automatic run_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                          input int n, input int dcyc, input logic [3:0] dop,
                          input logic [31:0] da, input logic [31:0] db, input logic dstart);
        int cyc;
        md_op = op; a = x; b = y; start = 1'b1;
        step();
        start = 1'b0; md_op = 4'(MD_NONE);
        cyc = 0;
        while (busy === 1'b1 && cyc < 200) begin
            cyc++;
            chk("hold_hi", hi_o, mdl_hi);
            chk("hold_lo", lo_o, mdl_lo);
            if (cyc == dcyc) begin
                md_op = dop; a = da; b = db; start = dstart;
            end else begin
                md_op = 4'(MD_NONE); start = 1'b0;
            end
            step();
        end
        md_op = 4'(MD_NONE); start = 1'b0;
        chk("busy_len", 32'(cyc), 32'(n));
        ref_op(op, x, y);
        chk("res_hi", hi_o, mdl_hi);
        chk("res_lo", lo_o, mdl_lo);
    endtask

    initial begin
        total = 0; bad = 0;
        mdl_hi = '0; mdl_lo = '0;
        rst = 1'b1; start = 1'b0; md_op = 4'(MD_NONE); a = '0; b = '0;
        step(); step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_hi", hi_o, 32'd0);
        chk("rst_lo", lo_o, 32'd0);
        rst = 1'b0;
        step();

        // 1: MULT -2 * 3, then MFLO
        run_op(4'(MD_MULT), 32'hFFFF_FFFE, 32'd3, 5, 0, 4'(MD_NONE), 0, 0, 1'b0);
        chk("t1_hi", hi_o, 32'hFFFF_FFFF);
        chk("t1_lo", lo_o, 32'hFFFF_FFFA);
        md_op = 4'(MD_MFLO); #1;
        chk("t1_mflo", md_out, 32'hFFFF_FFFA);
        md_op = 4'(MD_NONE); #1;
        chk("t1_none", md_out, 32'd0);

        // 2: MULTU max * max
        run_op(4'(MD_MULTU), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 0, 4'(MD_NONE), 0, 0, 1'b0);
        chk("t2_hi", hi_o, 32'hFFFF_FFFE);
        chk("t2_lo", lo_o, 32'h0000_0001);

        // 3: DIV -7 / 2, then DIVU by zero leaves HI/LO alone
        run_op(4'(MD_DIV), 32'hFFFF_FFF9, 32'd2, 10, 0, 4'(MD_NONE), 0, 0, 1'b0);
        chk("t3_lo", lo_o, 32'hFFFF_FFFD);
        chk("t3_hi", hi_o, 32'hFFFF_FFFF);
        run_op(4'(MD_DIVU), 32'd7, 32'd0, 10, 0, 4'(MD_NONE), 0, 0, 1'b0);
        chk("t3_dbz_lo", lo_o, 32'hFFFF_FFFD);
        chk("t3_dbz_hi", hi_o, 32'hFFFF_FFFF);

        // Signed overflow corner
        run_op(4'(MD_DIV), 32'h8000_0000, 32'hFFFF_FFFF, 10, 0, 4'(MD_NONE), 0, 0, 1'b0);
        chk("ovf_lo", lo_o, 32'h8000_0000);
        chk("ovf_hi", hi_o, 32'h0000_0000);

        // 4: MTHI / MFHI, MTLO idle, then MTLO ignored while busy
        md_op = 4'(MD_MTHI); a = 32'h1234_5678;
        step();
        mdl_hi = 32'h1234_5678;
        md_op = 4'(MD_MFHI); #1;
        chk("t4_mfhi", md_out, 32'h1234_5678);
        md_op = 4'(MD_MTLO); a = 32'hCAFE_F00D;
        step();
        mdl_lo = 32'hCAFE_F00D;
        md_op = 4'(MD_MFLO); #1;
        chk("t4_mflo", md_out, 32'hCAFE_F00D);
        md_op = 4'(MD_NONE);
        run_op(4'(MD_MULT), 32'd1000, 32'hFFFF_FF00, 5, 2, 4'(MD_MTLO), 32'hDEAD_BEEF, 0, 1'b0);
        chk("t4_lo_mult", lo_o, 32'hFFFC_1800);

        // 5: second start while busy is ignored
        run_op(4'(MD_DIV), 32'd100, 32'd7, 10, 3, 4'(MD_MULTU), 32'h0000_FFFF, 32'h0000_FFFF, 1'b1);
        chk("t5_lo", lo_o, 32'd14);
        chk("t5_hi", hi_o, 32'd2);

        // start with a non-arithmetic op does nothing
        md_op = 4'(MD_MFHI); start = 1'b1;
        step();
        start = 1'b0; md_op = 4'(MD_NONE);
        chk("nostart_busy", 32'(busy), 32'd0);

        // Random mix
        for (int i = 0; i < 16; i++) begin
            logic [3:0]  op;
            logic [31:0] x;
            logic [31:0] y;
            op = 4'($urandom_range(1, 4));
            x  = $urandom;
            case ($urandom_range(0, 5))
                0:       y = 32'd0;
                1:       y = 32'($urandom_range(1, 9));
                default: y = $urandom;
            endcase
            run_op(op, x, y, (op <= 4'(MD_MULTU)) ? 5 : 10, 0, 4'(MD_NONE), 0, 0, 1'b0);
        end

        // 6: asynchronous reset mid-MULT
        chk("t6_pre_hi_nz", 32'(hi_o != 0 || lo_o != 0), 32'd1);
        md_op = 4'(MD_MULT); a = 32'd5; b = 32'd7; start = 1'b1;
        step();
        start = 1'b0; md_op = 4'(MD_NONE);
        step();
        #3;
        rst = 1'b1;
        #1;
        mdl_hi = '0; mdl_lo = '0;
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_hi", hi_o, 32'd0);
        chk("t6_lo", lo_o, 32'd0);
        step();
        #3;
        rst = 1'b0;
        step();
        run_op(4'(MD_MULT), 32'd5, 32'd7, 5, 0, 4'(MD_NONE), 0, 0, 1'b0);
        chk("t6_after_lo", lo_o, 32'd35);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mdu.md
Name: mdu

Overview:
- Multiply/divide unit in the E stage of the five-stage MIPS pipeline.
- Owns the HI/LO registers and models multi-cycle MULT/MULTU/DIV/DIVU latency with a busy counter.
- Provides MFHI/MFLO read data, which travels down the pipeline as the MD output field through the M stage and into the W-stage register for GRF write-back.
- Hazard control uses busy/start to stall D-stage MD instructions.

Parameters:
- MULT_CYCLES, 5, busy duration in cycles for MULT/MULTU.
- DIV_CYCLES, 10, busy duration in cycles for DIV/DIVU.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- start  input  1  single-cycle pulse from the E stage when a MULT/MULTU/DIV/DIVU is in E
- md_op  input  4  operation code (see package); NONE when the E instruction is not an MD instruction
- a  input  32  rs operand (forwarded)
- b  input  32  rt operand (forwarded)
- busy  output  1  high while a multiply/divide is in flight
- md_out  output  32  HI for MFHI, LO for MFLO, otherwise 0; combinational
- hi_o  output  32  current HI register, for debug
- lo_o  output  32  current LO register, for debug

Behaviour:
- Reset (asynchronous, active-high): HI=0, LO=0, busy=0, counter=0, pending results=0. The block holds this state while reset is high.
- Accepted start (rising edge with start=1, busy=0, md_op in {MULT, MULTU, DIV, DIVU}):
  - compute the result from a/b and store it in pending_hi/pending_lo;
  - load counter with MULT_CYCLES or DIV_CYCLES;
  - set busy=1.
- busy timing:
  - busy is 1 for exactly N cycles after the accepting edge.
  - On the edge where counter==1: HI<=pending_hi, LO<=pending_lo, busy<=0, counter<=0.
  - Otherwise counter decrements by 1 each edge.
- Architectural HI/LO are unchanged while busy. hi_o/lo_o show old values until completion.
- MULT: signed 32x32 -> 64; HI=upper 32 bits, LO=lower 32 bits. MULTU: the same operation, unsigned.
- DIV (signed):
  - LO = quotient, truncated toward zero;
  - HI = remainder, which takes the sign of the dividend;
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- DIVU: unsigned quotient and remainder.
- Divide by zero: start is accepted and busy runs the full DIV_CYCLES, but HI/LO stay unchanged at completion.
- MTHI/MTLO:
  - when busy=0, HI<=a (or LO<=a) at the edge;
  - when busy=1, the write is ignored.
- start while busy=1: ignored, with no effect on the counter or pending results. The controller guarantees this never happens; the bench checks the ignore.
- md_out:
  - md_op==MFHI gives HI; md_op==MFLO gives LO;
  - otherwise 0;
  - independent of busy, since the controller stalls MFHI/MFLO while busy.
- start=1 with md_op not mult/div: ignored.
- Reset mid-operation: the operation is aborted, busy drops immediately without waiting for a clock, and HI/LO read 0.

Decomposition:
- Shared package md_pkg holds:
  - md_op codes: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8;
  - default cycle constants;
  - a helper that classifies md_op as "is_md_start" (ops 1-4) or "is_md_use" (ops 1-8). Hazard control uses is_md_use for stalls.
- One sub-module, mdu_arith: combinational; takes (md_op, a, b) and returns {hi, lo, div_by_zero}.
- The mdu top holds the counter, busy, pending registers and HI/LO.

Test Plan:
1. MULT a=0xFFFFFFFE (-2), b=3, start 1 cycle:
   - busy high exactly 5 cycles;
   - then HI=0xFFFFFFFF, LO=0xFFFFFFFA;
   - MFLO reads 0xFFFFFFFA.
2. MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
3. DIV a=-7 (0xFFFFFFF9), b=2:
   - busy 10 cycles;
   - LO=0xFFFFFFFD, HI=0xFFFFFFFF.
   - Then DIVU a=7, b=0 -> busy 10 cycles, HI/LO unchanged.
4. MTHI a=0x12345678, then MFHI -> md_out=0x12345678.
   - MTLO issued while busy from a MULT -> LO ends with the MULT result, not the MTLO data.
5. Start DIV, then a second start at cycle 3 with a different op:
   - ignored;
   - busy still falls at cycle 10;
   - result matches the first op.
6. Start MULT, assert reset asynchronously at cycle 2 between clock edges:
   - busy=0 and HI=LO=0 immediately;
   - after release, the next MULT runs normally.
